pctrl_gen: RTL

Parametrised serial packet controller, successor to the fixed-format packet controller. Deserialises one-bit-per-clock packets on rx: start bit, address, opcode, payload, stop bit. Accepts packets addressed to this node or to broadcast, and presents opcode and payload with a one-cycle valid strobe. A registered tx copy of rx allows nodes to be daisy-chained. Adds framing-error detection and a busy flag.

---
 rtl/pctrl_pkg.sv | 37 +++
 rtl/pctrl_shreg.sv | 36 +++
 rtl/pctrl_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pctrl_pkg.sv
// Shared definitions for the serial packet controller: FSM state encoding,
// default field widths and packet-geometry helpers.
package pctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_OP   = 3'd2,
    ST_DATA = 3'd3,
    ST_STOP = 3'd4
  } state_e;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_OP_W   = 3;
  localparam int unsigned DEF_DATA_W = 62;

  // Total serial length of one packet: start bit, three fields, stop bit.
  function automatic int unsigned pkt_len(input int unsigned addr_w,
                                          input int unsigned op_w,
                                          input int unsigned data_w);
    return addr_w + op_w + data_w + 32'd2;
  endfunction

  // Widest of the three fields; sizes the shared field counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

endpackage

// File: rtl/pctrl_shreg.sv
// MSB-first shift register: each enabled clock moves the register left and
// places the new serial bit in the LSB, so after W shifts the first bit
// received sits in the MSB.
module pctrl_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  generate
    if (W == 1) begin : g_single
      // Single-bit field: the register simply captures the bit when enabled.
      always_ff @(posedge clk) begin
        if (!nRst) q_q <= 1'b0;
        else if (en_i) q_q <= bit_i;
        else q_q <= q_q;
      end
    end else begin : g_multi
      // Multi-bit field: shift left, new bit enters at the LSB.
      always_ff @(posedge clk) begin
        if (!nRst) q_q <= {W{1'b0}};
        else if (en_i) q_q <= {q_q[W-2:0], bit_i};
        else q_q <= q_q;
      end
    end
  endgenerate

  assign q_o = q_q;

endmodule

// File: rtl/pctrl_gen.sv
// Parametrised serial packet controller. Receives start/address/opcode/
// payload/stop one bit per clock, accepts packets for this node (or the
// broadcast address when enabled), and forwards rx to tx for daisy-chaining.
module pctrl_gen
  import pctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned OP_W     = DEF_OP_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter bit          BCAST_EN = 1'b1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rx,
  output logic              tx,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              err,
  output logic              busy
);

  localparam int unsigned MAX_W = max3(ADDR_W, OP_W, DATA_W);
  localparam int unsigned CNT_W = ($clog2(MAX_W) > 0) ? $clog2(MAX_W) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tx_q;
  logic [OP_W-1:0]    opcode_q;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               err_q;
  logic               busy_q;

  logic               en_addr_s;
  logic               en_op_s;
  logic               en_data_s;
  logic [ADDR_W-1:0]  rx_addr_s;
  logic [OP_W-1:0]    rx_op_s;
  logic [DATA_W-1:0]  rx_data_s;
  logic               addr_match_s;

  // Shift enables follow the field currently being received.
  always_comb begin
    en_addr_s = 1'b0;
    en_op_s   = 1'b0;
    en_data_s = 1'b0;
    case (state_q)
      ST_ADDR: en_addr_s = 1'b1;
      ST_OP:   en_op_s   = 1'b1;
      ST_DATA: en_data_s = 1'b1;
      default: begin
        en_addr_s = 1'b0;
        en_op_s   = 1'b0;
        en_data_s = 1'b0;
      end
    endcase
  end

  pctrl_shreg #(.W(ADDR_W)) u_addr_sr (
    .clk   (clk),
    .nRst  (nRst),
    .en_i  (en_addr_s),
    .bit_i (rx),
    .q_o   (rx_addr_s)
  );

  pctrl_shreg #(.W(OP_W)) u_op_sr (
    .clk   (clk),
    .nRst  (nRst),
    .en_i  (en_op_s),
    .bit_i (rx),
    .q_o   (rx_op_s)
  );

  pctrl_shreg #(.W(DATA_W)) u_data_sr (
    .clk   (clk),
    .nRst  (nRst),
    .en_i  (en_data_s),
    .bit_i (rx),
    .q_o   (rx_data_s)
  );

  // Address filter: exact node match, or all-ones when broadcast is enabled.
  always_comb begin
    addr_match_s = 1'b0;
    if (rx_addr_s == address) addr_match_s = 1'b1;
    else if (BCAST_EN && (rx_addr_s == {ADDR_W{1'b1}})) addr_match_s = 1'b1;
    else addr_match_s = 1'b0;
  end

  // Packet FSM with field counter and all registered outputs.
  // busy stays high through the cycle following the stop-bit edge so a
  // back-to-back start bit keeps it asserted without a gap.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      tx_q     <= 1'b1;
      opcode_q <= {OP_W{1'b0}};
      data_q   <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      tx_q    <= rx;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= (state_q != ST_IDLE) || !rx;
      case (state_q)
        ST_IDLE: begin
          if (!rx) begin
            state_q <= ST_ADDR;
            cnt_q   <= CNT_W'(ADDR_W - 1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= ST_OP;
            cnt_q   <= CNT_W'(OP_W - 1);
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1'b1);
          end
        end
        ST_OP: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= ST_DATA;
            cnt_q   <= CNT_W'(DATA_W - 1);
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1'b1);
          end
        end
        ST_DATA: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= ST_STOP;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1'b1);
          end
        end
        ST_STOP: begin
          state_q <= ST_IDLE;
          if (!rx) begin
            err_q <= 1'b1;
          end else if (addr_match_s) begin
            valid_q  <= 1'b1;
            opcode_q <= rx_op_s;
            data_q   <= rx_data_s;
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign tx     = tx_q;
  assign opcode = opcode_q;
  assign data   = data_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule
